// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Instruction-memory request/ready port between the fetch stage
//            (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch plus IF/ID pipeline register. Owns the fetch
//            PC, honours the decode stall (keep) and the decode-resolved
//            redirect while keeping the branch delay slot alive.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,          // asynchronous, active-low
    input  wire logic        keep,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    if_stage_if.master       imem,
    output logic             id_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_4,
    output logic [31:0]      instruction
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_next;
    logic [31:0] fpc;
    logic [31:0] fpc_plus4;
    logic [31:0] hold_buf;
    logic        pend_valid;
    logic [31:0] pend_pc;

    logic        accept;
    logic        deliver;
    logic        capture;
    logic        redirect_seen;
    logic [31:0] nextpc;
    logic [31:0] deliver_data;

    // Request is gated by reset so nothing is asked of memory while held in reset.
    assign imem.req  = (state == FETCH) && reset;
    assign imem.addr = fpc;

    assign fpc_plus4 = fpc + 32'd4;

    // Handshake decode, delay-slot aware next-PC selection and FSM next state.
    always_comb begin
        state_next    = state;
        accept        = !keep || !id_valid;
        redirect_seen = redirect_valid && !keep;
        capture       = 1'b0;
        deliver       = 1'b0;
        deliver_data  = imem.rdata;
        nextpc        = fpc_plus4;

        unique case (state)
            FETCH: begin
                deliver = accept && imem.ready;
                capture = !accept && imem.ready;
                if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                deliver      = accept;
                deliver_data = hold_buf;
                if (accept) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // The instruction delivered now is the delay slot, so the target
        // takes effect for the fetch that follows it.
        if (redirect_seen && deliver) begin
            nextpc = redirect_pc & WORD_MASK;
        end else if (pend_valid) begin
            nextpc = pend_pc;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC advances only when an instruction leaves for decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc <= RESET_PC & WORD_MASK;
        end else if (deliver) begin
            fpc <= nextpc;
        end
    end

    // Parks returned data while decode is stalled, so the request can drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_buf <= NOP_INSN;
        end else if (capture) begin
            hold_buf <= imem.rdata;
        end
    end

    // Remembers a redirect that arrived before its delay slot was delivered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0000_0000;
        end else if (deliver) begin
            pend_valid <= 1'b0;
        end else if (redirect_seen) begin
            pend_valid <= 1'b1;
            pend_pc    <= redirect_pc & WORD_MASK;
        end
    end

    // IF/ID register: load on deliver, bubble when free but empty, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid    <= 1'b0;
            pc          <= 32'h0000_0000;
            pc_4        <= 32'h0000_0000;
            instruction <= NOP_INSN;
        end else if (deliver) begin
            id_valid    <= 1'b1;
            pc          <= fpc;
            pc_4        <= fpc_plus4;
            instruction <= deliver_data;
        end else if (accept) begin
            id_valid    <= 1'b0;
            instruction <= NOP_INSN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed scenarios followed by
//            random keep/redirect/ready traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        keep = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instruction;

    int n_checks = 0;
    int n_errors = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .keep           (keep),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .id_valid       (id_valid),
        .pc             (pc),
        .pc_4           (pc_4),
        .instruction    (instruction)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.rdata = mem_word(bus.addr);

    // Behavioural model: fetch address, data waiting for decode, pending target.
    logic [31:0] m_fpc;
    logic        m_idv;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_insn;
    logic [31:0] held[$];
    logic [31:0] pend[$];

    task automatic model_reset();
        m_fpc  = RESET_PC & 32'hFFFF_FFFC;
        m_idv  = 1'b0;
        m_pc   = 32'h0;
        m_pc4  = 32'h0;
        m_insn = NOP;
        held.delete();
        pend.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idif(input string tag);
        check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_idv});
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_4"}, pc_4, m_pc4);
        check({tag, ".insn"}, instruction, m_insn);
    endtask

    // One clock: drive inputs, check the request side, advance model, check IF/ID.
    task automatic step(input logic k, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input string tag);
        logic        can_take;
        logic        got;
        logic [31:0] data;
        logic        redir;
        keep           = k;
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.ready      = rdy;
        #1;
        check({tag, ".req"}, {31'b0, bus.req}, {31'b0, held.size() == 0});
        if (held.size() == 0) check({tag, ".addr"}, bus.addr, m_fpc);

        can_take = !k || !m_idv;
        got      = (held.size() != 0) || rdy;
        data     = (held.size() != 0) ? held[0] : mem_word(m_fpc);
        redir    = rv && !k;
        if (can_take && got) begin
            m_idv  = 1'b1;
            m_pc   = m_fpc;
            m_pc4  = m_fpc + 32'd4;
            m_insn = data;
            held.delete();
            if (redir)                 m_fpc = rpc & 32'hFFFF_FFFC;
            else if (pend.size() != 0) m_fpc = pend[0];
            else                       m_fpc = m_fpc + 32'd4;
            pend.delete();
        end else begin
            if (can_take) begin
                m_idv  = 1'b0;
                m_insn = NOP;
            end
            if (got && held.size() == 0) held.push_back(data);
            if (redir) begin
                pend.delete();
                pend.push_back(rpc & 32'hFFFF_FFFC);
            end
        end
        @(posedge clk);
        #1;
        check_idif(tag);
    endtask

    // Directed scenarios, random traffic, then asynchronous reset mid-wait.
    initial begin
        bus.ready = 1'b0;
        model_reset();
        #3;
        check_idif("reset");
        check("reset.req", {31'b0, bus.req}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Streaming with memory always ready.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "t1_stream");
        // Memory answers after three waiting cycles.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, "t2_wait");
        step(1'b0, 1'b0, 32'h0, 1'b1, "t2_ready");
        // Decode stall while a fetch completes.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, "t3_keep");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "t3_release");
        // Redirect on a deliver cycle.
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1, "t4_redirect");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "t4_after");
        // Redirect while the delay-slot fetch is still waiting.
        step(1'b0, 1'b1, 32'h0000_0080, 1'b0, "t5_redirect");
        step(1'b0, 1'b0, 32'h0, 1'b0, "t5_wait");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "t5_after");
        // Misaligned target and wrap-around past the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, "wrap_redirect");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "wrap_after");
        // Redirect ignored while stalled.
        step(1'b1, 1'b1, 32'h0000_0400, 1'b1, "keep_redirect");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "keep_redirect_after");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom,
                 $urandom_range(0, 2) != 0, "random");
        end

        // Asynchronous reset in the middle of a waiting request.
        keep = 1'b0; redirect_valid = 1'b0; bus.ready = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_idif("t6_reset");
        check("t6_reset.req", {31'b0, bus.req}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_release.req", {31'b0, bus.req}, 32'h1);
        check("t6_release.addr", bus.addr, RESET_PC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "t6_stream");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
